matrix_result_sender: RTL and testbench

Serializes one 3x3 result matrix into a byte stream for the UART transmitter, which it drives through the tx_data/tx_start/tx_busy handshake. It sits between the matrix-multiply pipeline output and the UART TX stage. Each frame is a header byte followed by the nine elements in row-major order, MSB byte first. An XOR checksum byte can be appended as a build option.

---
 rtl/matrix_uart_pkg.sv | 30 +++
 rtl/byte_mux.sv | 46 ++++
 rtl/matrix_result_sender.sv | 130 +++++++++++++
 tb/tb_matrix_result_sender.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_uart_pkg.sv
// Shared definitions for the matrix result path feeding the UART transmitter.
// Contents: matrix dimensions, default frame header, sender FSM state type and
// the frame byte-count function.
// Build option: SENDER_CHECKSUM_EN appends one XOR checksum byte to each frame.
package matrix_uart_pkg;

  localparam int unsigned MAT_DIM   = 3;
  localparam int unsigned MAT_ELEMS = MAT_DIM * MAT_DIM;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStrobe,
    StWaitAck,
    StWaitDone,
    StFin
  } state_e;

  // Bytes per frame: header + all element bytes (+ checksum when enabled).
  function automatic int unsigned frame_bytes(int unsigned elem_w);
`ifdef SENDER_CHECKSUM_EN
    return 2 + (MAT_ELEMS * elem_w) / 8;
`else
    return 1 + (MAT_ELEMS * elem_w) / 8;
`endif
  endfunction

endpackage

// File: rtl/byte_mux.sv
// Combinational frame byte selector.
// Maps byte index idx_i to the byte transmitted at that position:
// index 0 is the header, then each element MSB byte first in row-major order,
// and (with SENDER_CHECKSUM_EN) the checksum as the last byte.
// Ports:
//   header_i  frame header byte
//   shadow_i  captured matrix, element e at [e*ELEM_W +: ELEM_W]
//   cksum_i   running checksum (only with SENDER_CHECKSUM_EN)
//   idx_i     byte index within the frame
//   byte_o    selected byte (0 for out-of-range indices)
module byte_mux
  import matrix_uart_pkg::*;
#(
  parameter int unsigned ELEM_W = 16,
  parameter int unsigned NB     = frame_bytes(ELEM_W),
  parameter int unsigned IDX_W  = $clog2(NB)
) (
  input  logic [7:0]                  header_i,
  input  logic [MAT_ELEMS*ELEM_W-1:0] shadow_i,
`ifdef SENDER_CHECKSUM_EN
  input  logic [7:0]                  cksum_i,
`endif
  input  logic [IDX_W-1:0]            idx_i,
  output logic [7:0]                  byte_o
);

  localparam int unsigned BPE = ELEM_W / 8;

  logic [7:0] frame_bytes_q [NB];

  always_comb begin
    frame_bytes_q[0] = header_i;
    for (int unsigned e = 0; e < MAT_ELEMS; e++) begin
      for (int unsigned b = 0; b < BPE; b++) begin
        // b = 0 is the most significant byte of the element.
        frame_bytes_q[1 + e * BPE + b] = shadow_i[e * ELEM_W + (BPE - 1 - b) * 8 +: 8];
      end
    end
`ifdef SENDER_CHECKSUM_EN
    frame_bytes_q[NB-1] = cksum_i;
`endif
  end

  assign byte_o = (32'(idx_i) < NB) ? frame_bytes_q[idx_i] : 8'h00;

endmodule

// File: rtl/matrix_result_sender.sv
// Serializes one 3x3 result matrix into a UART byte stream.
// Frame: HEADER, then the nine elements row-major, MSB byte first, optionally
// followed by an XOR checksum of the data bytes (build option SENDER_CHECKSUM_EN).
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   start_i      1-cycle frame request, accepted only when idle
//   mat_flat_i   matrix, element (r,c) at [(3r+c)*ELEM_W +: ELEM_W]
//   busy_o       frame in progress
//   done_o       1-cycle pulse after the last byte completes
//   tx_data_o    byte to the UART, stable from load until its transfer ends
//   tx_start_o   1-cycle strobe to the UART
//   tx_busy_i    UART busy flag
module matrix_result_sender
  import matrix_uart_pkg::*;
#(
  parameter int unsigned ELEM_W = 16,
  parameter logic [7:0]  HEADER = DEFAULT_HEADER
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_i,
  input  logic [MAT_ELEMS*ELEM_W-1:0] mat_flat_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [7:0]                  tx_data_o,
  output logic                        tx_start_o,
  input  logic                        tx_busy_i
);

  localparam int unsigned NB       = frame_bytes(ELEM_W);
  localparam int unsigned IDX_W    = $clog2(NB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [MAT_ELEMS*ELEM_W-1:0] shadow_q, shadow_d;
  logic [7:0]                  byte_sel;
`ifdef SENDER_CHECKSUM_EN
  logic [7:0]                  cksum_q, cksum_d;
`endif

  byte_mux #(
    .ELEM_W (ELEM_W),
    .NB     (NB),
    .IDX_W  (IDX_W)
  ) u_byte_mux (
    .header_i (HEADER),
    .shadow_i (shadow_q),
`ifdef SENDER_CHECKSUM_EN
    .cksum_i  (cksum_q),
`endif
    .idx_i    (idx_q),
    .byte_o   (byte_sel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      shadow_q <= '0;
`ifdef SENDER_CHECKSUM_EN
      cksum_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
`ifdef SENDER_CHECKSUM_EN
      cksum_q  <= cksum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
`ifdef SENDER_CHECKSUM_EN
    cksum_d  = cksum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          shadow_d = mat_flat_i;
          idx_d    = '0;
`ifdef SENDER_CHECKSUM_EN
          cksum_d  = '0;
`endif
          state_d  = StLoad;
        end
      end
      StLoad: begin
        // An earlier transfer still in flight delays the strobe.
        if (!tx_busy_i) state_d = StStrobe;
      end
      StStrobe: begin
`ifdef SENDER_CHECKSUM_EN
        // Header and the checksum byte itself are not folded.
        if (idx_q != '0 && idx_q != LAST_IDX) cksum_d = cksum_q ^ byte_sel;
`endif
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (tx_busy_i) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (!tx_busy_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = StLoad;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy_o     = state_q inside {StLoad, StStrobe, StWaitAck, StWaitDone};
  assign done_o     = (state_q == StFin);
  assign tx_start_o = (state_q == StStrobe);
  assign tx_data_o  = busy_o ? byte_sel : 8'h00;

endmodule

// File: tb/tb_matrix_result_sender.sv
module tb_matrix_result_sender;

`ifdef SENDER_CHECKSUM_EN
  localparam int NB = 20;
`else
  localparam int NB = 19;
`endif
  localparam int EW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [9*EW-1:0] mat;
  logic          busy, done, tx_start, tx_busy;
  logic [7:0]    tx_data;
  logic          hold_busy;

  int checks = 0;
  int errors = 0;

  matrix_result_sender #(
    .ELEM_W (EW),
    .HEADER (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .mat_flat_i (mat),
    .busy_o     (busy),
    .done_o     (done),
    .tx_data_o  (tx_data),
    .tx_start_o (tx_start),
    .tx_busy_i  (tx_busy)
  );

  always #5 clk = ~clk;

  // UART model: busy for 10 cycles starting the cycle after a strobe.
  int uart_cnt;
  assign tx_busy = (uart_cnt != 0) || hold_busy;
  always @(posedge clk or posedge reset) begin
    if (reset) uart_cnt <= 0;
    else if (tx_start) uart_cnt <= 10;
    else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
  end

  // Monitor: log strobed bytes and done pulses.
  logic [7:0] log_q[$];
  int n_start = 0;
  int n_done  = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_start) begin
        log_q.push_back(tx_data);
        n_start++;
      end
      if (done) n_done++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [9*EW-1:0] pattern();
    logic [9*EW-1:0] m;
    for (int e = 0; e < 9; e++) m[e*EW +: EW] = 16'(e + 1);
    return m;
  endfunction

  // Expected byte i of a frame carrying elements 0x0001..0x0009.
  function automatic logic [7:0] exp_byte(input int i);
    logic [7:0] x;
    logic [15:0] el;
    if (i == 0) return 8'hA5;
    if (i == 19) begin
      x = 8'h00;
      for (int e = 0; e < 9; e++) begin
        el = 16'(e + 1);
        x = x ^ el[15:8] ^ el[7:0];
      end
      return x;
    end
    el = 16'((i - 1) / 2 + 1);
    return ((i - 1) % 2 == 0) ? el[15:8] : el[7:0];
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; hold_busy = 1'b0; mat = '0;
    tick(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_single_frame();
    int lb = log_q.size();
    int sb = n_start;
    int db = n_done;
    logic b1 = 1'b0, b2 = 1'b0;
    bit seen = 0;
    mat = pattern();
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy_c1 got %b want 1", busy); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL frame_hdr_c1 got %h want a5", tx_data); end
    for (int i = 0; i < 1000 && !seen; i++) begin
      b2 = b1; b1 = tx_busy;
      tick(1);
      if (done === 1'b1) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL frame_done_timeout got 0 want 1"); end
    checks++; if (b1 !== 1'b0 || b2 !== 1'b1) begin
      errors++; $display("FAIL frame_done_latency got busy_hist %b%b want 10", b2, b1);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_at_done got %b want 0", busy); end
    tick(5);
    checks++; if (n_start - sb != NB) begin errors++; $display("FAIL frame_strobes got %0d want %0d", n_start - sb, NB); end
    checks++; if (n_done - db != 1) begin errors++; $display("FAIL frame_dones got %0d want 1", n_done - db); end
    for (int i = 0; i < NB && lb + i < log_q.size(); i++) begin
      checks++;
      if (log_q[lb + i] !== exp_byte(i)) begin
        errors++; $display("FAIL frame_byte%0d got %h want %h", i, log_q[lb + i], exp_byte(i));
      end
    end
  endtask

  task automatic test_ignore_start();
    int lb = log_q.size();
    int sb = n_start;
    int db = n_done;
    int drops = 0;
    bit seen = 0;
    mat = pattern();
    pulse_start();
    tick(20);
    mat = '1;
    pulse_start();
    for (int i = 0; i < 1000 && !seen; i++) begin
      if (done === 1'b1) seen = 1;
      else if (busy !== 1'b1) drops++;
      if (!seen) tick(1);
    end
    checks++; if (!seen) begin errors++; $display("FAIL ignore_done_timeout got 0 want 1"); end
    checks++; if (drops != 0) begin errors++; $display("FAIL ignore_busy_drops got %0d want 0", drops); end
    tick(40);
    checks++; if (n_start - sb != NB) begin errors++; $display("FAIL ignore_strobes got %0d want %0d", n_start - sb, NB); end
    checks++; if (n_done - db != 1) begin errors++; $display("FAIL ignore_dones got %0d want 1", n_done - db); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_after got %b want 0", busy); end
    for (int i = 0; i < NB && lb + i < log_q.size(); i++) begin
      checks++;
      if (log_q[lb + i] !== exp_byte(i)) begin
        errors++; $display("FAIL ignore_byte%0d got %h want %h", i, log_q[lb + i], exp_byte(i));
      end
    end
  endtask

  task automatic test_busy_hold();
    int sb = n_start;
    int db = n_done;
    int bad = 0;
    bit seen = 0;
    hold_busy = 1'b1;
    mat = pattern();
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      if (tx_start !== 1'b0 || tx_data !== 8'hA5 || busy !== 1'b1) bad++;
      tick(1);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
    checks++; if (n_start != sb) begin errors++; $display("FAIL hold_no_strobe got %0d want 0", n_start - sb); end
    hold_busy = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      tick(1);
      if (tx_start === 1'b1) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL hold_strobe_after got 0 want 1"); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL hold_strobe_data got %h want a5", tx_data); end
    seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      tick(1);
      if (done === 1'b1) seen = 1;
    end
    tick(3);
    checks++; if (n_start - sb != NB || n_done - db != 1) begin
      errors++; $display("FAIL hold_frame got %0d strobes %0d dones want %0d 1", n_start - sb, n_done - db, NB);
    end
  endtask

  task automatic test_reset_mid();
    int sb = n_start;
    int db;
    int lb;
    bit seen = 0;
    mat = pattern();
    pulse_start();
    for (int i = 0; i < 1000 && n_start - sb < 8; i++) tick(1);
    checks++; if (n_start - sb != 8) begin errors++; $display("FAIL rmid_reach got %0d want 8", n_start - sb); end
    tick(4);
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got %b want 0", done); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rmid_tx_start got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rmid_tx_data got %h want 00", tx_data); end
    tick(1);
    reset = 1'b0;
    sb = n_start; db = n_done;
    tick(40);
    checks++; if (n_start != sb || n_done != db) begin
      errors++; $display("FAIL rmid_quiet got %0d strobes %0d dones want 0 0", n_start - sb, n_done - db);
    end
    lb = log_q.size();
    pulse_start();
    for (int i = 0; i < 1000 && !seen; i++) begin
      tick(1);
      if (done === 1'b1) seen = 1;
    end
    tick(3);
    checks++; if (n_start - sb != NB || n_done - db != 1) begin
      errors++; $display("FAIL rmid_restart got %0d strobes %0d dones want %0d 1", n_start - sb, n_done - db, NB);
    end
    checks++; if (log_q.size() <= lb || log_q[lb] !== 8'hA5) begin
      errors++; $display("FAIL rmid_first_byte got %h want a5", (log_q.size() > lb) ? log_q[lb] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    int sb = n_start;
    int db = n_done;
    bit seen = 0;
    mat = pattern();
    start = 1'b1;
    tick(1);
    for (int i = 0; i < 1000 && !seen; i++) begin
      tick(1);
      if (done === 1'b1) seen = 1;
    end
    checks++; if (!seen || busy !== 1'b0) begin errors++; $display("FAIL b2b_first_done got %b busy %b want 1 0", seen, busy); end
    tick(1);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_gap got busy %b done %b want 0 0", busy, done);
    end
    tick(1);
    checks++; if (busy !== 1'b1 || tx_data !== 8'hA5) begin
      errors++; $display("FAIL b2b_second_load got busy %b data %h want 1 a5", busy, tx_data);
    end
    seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      tick(1);
      if (done === 1'b1) seen = 1;
    end
    start = 1'b0;
    tick(30);
    checks++; if (n_done - db != 2) begin errors++; $display("FAIL b2b_dones got %0d want 2", n_done - db); end
    checks++; if (n_start - sb != 2 * NB) begin errors++; $display("FAIL b2b_strobes got %0d want %0d", n_start - sb, 2 * NB); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_ignore_start();
    test_busy_hold();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
